keypad_scanner: RTL
===================

# keypad_scanner

Input-side companion to the seven-segment presenter: scans a 4x4 hex matrix keypad by driving rows low one at a time and reading pulled-up columns. Debounces the key, emits a one-cycle key event with its 4-bit code, and shifts accepted digits into a 16-bit value register. That register is the value the CPU's input port reads and the presenter displays.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per scan tick; minimum 2.
- DEBOUNCE_TICKS, 4: consecutive matching ticks needed to accept a press or a release; minimum 1.
- REPEAT_TICKS, 64: ticks between auto-repeat events while held; used only with KEYPAD_REPEAT_EN; minimum 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-low.
- col  in  4  keypad columns, active-low, asynchronous to clk.
- clr  in  1  synchronous clear of value.
- row  out  4  keypad row drive, one-hot active-low.
- key_valid  out  1  one-cycle pulse per accepted key event.
- key_code  out  4  code of the last event = {row_idx[1:0], col_idx[1:0]}.
- key_down  out  1  high while a key is held (HELD or RELEASE state).
- value  out  16  hex entry shift register.

## Operation
- col passes through a 2-flop synchronizer (col_s) before any use. "Pressed" means col_s != 4'hF.
- Tick generator: div_cnt counts 0..SCAN_DIV-1 and wraps. tick is high for the one cycle in which div_cnt == SCAN_DIV-1.
- All state decisions happen only on tick cycles, sampling col_s at that cycle.
- col_idx is the index of the lowest low bit of col_s.
- FSM states:
  - SCAN:
    - pressed: latch row_idx and col_idx, cnt=1, go to DEBOUNCE. The row freezes.
    - not pressed: row_idx++ (mod 4).
  - DEBOUNCE:
    - same col_idx still low: cnt++. When cnt reaches DEBOUNCE_TICKS, go to HELD and emit the event.
    - otherwise: go to SCAN and row_idx++.
    - With DEBOUNCE_TICKS=1, acceptance happens on the first tick, going directly SCAN→HELD.
  - HELD:
    - not pressed: cnt=1, go to RELEASE.
    - pressed: stay.
  - RELEASE:
    - not pressed: cnt++. At DEBOUNCE_TICKS go to SCAN with row_idx++.
    - pressed: go back to HELD with no new event.
- Event: key_code <= {row_idx, col_idx}, key_valid=1 for exactly one cycle, value <= {value[11:0], code}.
- clr: value <= 0. If clr coincides with an event, clr wins: value becomes 0 and the digit is dropped. key_valid and key_code still update.
- A second key pressed while HELD is ignored; the row stays frozen on the first key.

## Timing
- Reset (rst=0 at a clk edge): row=4'b1110, key_valid=0, key_code=0, key_down=0, value=0, FSM=SCAN, div_cnt=0, cnt=0, synchronizer=4'hF.
- row changes in the cycle after a tick and is stable for SCAN_DIV cycles before the next sample.
- key_valid is registered: it asserts in the cycle after the accepting tick. value and key_code update on that same edge.
- key_down rises with key_valid and falls the cycle after the tick that returns the FSM to SCAN.
- Minimum press-to-event latency: 2 sync cycles + DEBOUNCE_TICKS ticks.
- Reset mid-debounce or while held discards the key, with no event.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In HELD, a repeat counter increments each tick while pressed. At REPEAT_TICKS it resets and re-emits the event (same code, value shifts again).
  - The counter clears on entry to HELD, including entry from RELEASE.
- Undefined: exactly one event per press, and the repeat counter is absent.

## Structure
- Package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - ROW_RESET = 4'b1110
  - COL_IDLE = 4'hF
  - localparam widths for cnt and the repeat counter
- Sub-module keypad_tick_gen: parameterized SCAN_DIV divider producing tick. Reusable by the display multiplexer.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=8.
- Reset, no keys → row cycles 1110→1101→1011→0111→1110, changing every 4 cycles; key_valid never asserts; value=0.
- Hold row 2/col 1 (col=4'b1101 while row=1011) for 5 ticks, then release → exactly one key_valid, key_code=4'h9, value=16'h0009, key_down high until 3 release ticks.
- Bounce: col low 2 ticks, high 1 tick, then stable → no event from the bounce; one event after 3 stable ticks.
- Enter keys 1,2,3,4,5 → value=16'h2345 (oldest digit shifted out).
- clr asserted in the key_valid cycle of key A → value=0, key_code=4'hA.
- KEYPAD_REPEAT_EN: hold key 7 for 3+20 ticks → 3 events (initial + 2 repeats), value=16'h0777. Without the macro → 1 event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'hF;

  // Counter widths; DEBOUNCE_TICKS must fit CNT_W and REPEAT_TICKS must fit REP_W.
  localparam int CNT_W = 8;
  localparam int REP_W = 16;

  function automatic logic [1:0] low_index(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else if (!c[3]) return 2'd3;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Free-running divider: tick is high for one clk cycle out of every SCAN_DIV.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce, key events and a 16-bit entry register.
// Define KEYPAD_REPEAT_EN to re-emit the held key every REPEAT_TICKS ticks.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic [15:0] value
);

  if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("keypad_scanner: parameter out of range");
  end

  logic             tick;
  logic [3:0]       col_meta, col_s;
  state_t           state, state_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [1:0]       lat_col, lat_col_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       col_idx;
  logic             pressed;
  logic             emit;
  logic [3:0]       emit_code;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_cnt, rep_nxt;
`endif

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    case (row_idx)
      2'd0:    row = ROW_RESET;
      2'd1:    row = {ROW_RESET[2:0], ROW_RESET[3]};
      2'd2:    row = {ROW_RESET[1:0], ROW_RESET[3:2]};
      default: row = {ROW_RESET[0], ROW_RESET[3:1]};
    endcase
  end

  assign key_down = (state == HELD) || (state == RELEASE);
  assign col_idx  = low_index(col_s);
  assign pressed  = (col_s != COL_IDLE);

  // Every decision is taken on tick; between ticks the state simply holds.
  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    lat_col_nxt = lat_col;
    cnt_nxt     = cnt;
    emit        = 1'b0;
    emit_code   = key_code;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt     = rep_cnt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          if (pressed) begin
            lat_col_nxt = col_idx;
            if (DEBOUNCE_TICKS == 1) begin
              state_nxt = HELD;
              emit      = 1'b1;
              emit_code = {row_idx, col_idx};
`ifdef KEYPAD_REPEAT_EN
              rep_nxt   = '0;
`endif
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = DEBOUNCE;
            end
          end else begin
            row_idx_nxt = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_s[lat_col]) begin
            if ((cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE_TICKS)) begin
              state_nxt = HELD;
              emit      = 1'b1;
              emit_code = {row_idx, lat_col};
`ifdef KEYPAD_REPEAT_EN
              rep_nxt   = '0;
`endif
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            state_nxt   = SCAN;
            row_idx_nxt = row_idx + 2'd1;
          end
        end
        HELD: begin
          if (!pressed) begin
            if (DEBOUNCE_TICKS == 1) begin
              state_nxt   = SCAN;
              row_idx_nxt = row_idx + 2'd1;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = RELEASE;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if ((rep_cnt + REP_W'(1)) == REP_W'(REPEAT_TICKS)) begin
              rep_nxt = '0;
              emit    = 1'b1;
            end else begin
              rep_nxt = rep_cnt + REP_W'(1);
            end
`endif
          end
        end
        RELEASE: begin
          if (!pressed) begin
            if ((cnt + CNT_W'(1)) == CNT_W'(DEBOUNCE_TICKS)) begin
              state_nxt   = SCAN;
              row_idx_nxt = row_idx + 2'd1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_nxt   = '0;
`endif
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  // clr has priority over a coinciding event, so that digit is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta  <= COL_IDLE;
      col_s     <= COL_IDLE;
      state     <= SCAN;
      row_idx   <= 2'd0;
      lat_col   <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      value     <= 16'h0000;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      col_meta  <= col;
      col_s     <= col_meta;
      state     <= state_nxt;
      row_idx   <= row_idx_nxt;
      lat_col   <= lat_col_nxt;
      cnt       <= cnt_nxt;
      key_valid <= emit;
      if (emit) key_code <= emit_code;
      if (clr)       value <= 16'h0000;
      else if (emit) value <= {value[11:0], emit_code};
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_nxt;
`endif
    end
  end

endmodule
